// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: state encoding, frame width, prescale limits.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state codes, default data width, smallest legal oversampling ratio,
// and a helper that decides whether a prescale value can run the receiver.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    // Below this ratio the three mid-bit samples used by data_sampling cannot be
    // voted and registered before the last edge of the bit.
    localparam logic [4:0] MIN_PRESCALE = 5'd6;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Even and at least MIN_PRESCALE; 5 bits cap the value at 31, which is odd,
    // so the upper limit of 30 falls out of the evenness test.
    function automatic logic prescale_legal(input logic [4:0] prescale);
        return (prescale[0] == 1'b0) && (prescale >= MIN_PRESCALE);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter (0..prescale-1, wraps) and received-bit counter for the UART RX FSM.
// Latency: counters update on the clock after enable/clear; bit_done is combinational from state.
// Backpressure: none; free-running while enabled, the FSM gates it via enable/clear.
//
// Ports: clk, reset_n (async, active low); clear zeroes both counters; enable advances edge_cnt;
// prescale is the frame-latched oversampling ratio; bit_clear zeroes bit_cnt; bit_en lets
// bit_cnt advance on bit_done; edge_cnt / bit_cnt are the counts; bit_done flags edge_cnt==P-1.
module uart_rx_edge_bit_counter #(
    parameter int BIT_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [4:0]           prescale,
    input  logic                 bit_clear,
    input  logic                 bit_en,
    output logic [4:0]           edge_cnt,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 bit_done
);

    assign bit_done = enable && (edge_cnt == (prescale - 5'd1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= '0;
        end else begin
            if (clear) begin
                edge_cnt <= 5'd0;
            end else if (enable) begin
                edge_cnt <= bit_done ? 5'd0 : (edge_cnt + 5'd1);
            end

            if (clear || bit_clear) begin
                bit_cnt <= '0;
            end else if (bit_en && bit_done) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detect, LSB-first deserialize, optional parity and stop check.
// Latency: data_valid/p_data one clock after the last edge of the stop bit; par_err one clock after parity bit.
// Backpressure: none; results are 1-cycle pulses, p_data_out holds the last good frame.
//
// Ports: clk, reset_n (async, active low); rx_in synchronized serial line (idle high);
// prescale_in / par_en_in / par_typ_in frame settings, latched when a start bit is seen;
// sampled_bit_in majority bit from data_sampling; data_sample_en_out enables data_sampling;
// edge_cnt_out edge index within the bit; p_data_out last good frame; data_valid_out,
// par_err_out, stp_err_out are single-cycle result pulses.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_in,
    input  logic [4:0]            prescale_in,
    input  logic                  par_en_in,
    input  logic                  par_typ_in,
    input  logic                  sampled_bit_in,
    output logic                  data_sample_en_out,
    output logic [4:0]            edge_cnt_out,
    output logic [DATA_WIDTH-1:0] p_data_out,
    output logic                  data_valid_out,
    output logic                  par_err_out,
    output logic                  stp_err_out
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [4:0]            prescale_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  frame_bad_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  bit_done;
    logic                  frame_start;
    logic                  cnt_clear;
    logic                  par_mismatch;

    assign frame_start  = (state == ST_IDLE) && (state_nxt == ST_START);
    // Leaving any state for IDLE zeroes the counters, so IDLE always shows edge_cnt 0
    // and the next START begins at edge 0.
    assign cnt_clear    = (state_nxt == ST_IDLE);
    assign par_mismatch = sampled_bit_in != (^shift_q ^ par_typ_q);

    // Decoded straight from the state register, so no rx_in-to-output path exists.
    assign data_sample_en_out = (state != ST_IDLE);

    uart_rx_edge_bit_counter #(
        .BIT_CNT_W (BIT_CNT_W)
    ) u_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (cnt_clear),
        .enable    (data_sample_en_out),
        .prescale  (prescale_q),
        .bit_clear (state == ST_START),
        .bit_en    (state == ST_DATA),
        .edge_cnt  (edge_cnt_out),
        .bit_cnt   (bit_cnt),
        .bit_done  (bit_done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!rx_in && prescale_legal(prescale_in)) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    // A start bit that votes high was a glitch on the line.
                    state_nxt = sampled_bit_in ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done && (bit_cnt == LAST_BIT)) begin
                    state_nxt = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            prescale_q     <= 5'd0;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            frame_bad_q    <= 1'b0;
            shift_q        <= '0;
            p_data_out     <= '0;
            data_valid_out <= 1'b0;
            par_err_out    <= 1'b0;
            stp_err_out    <= 1'b0;
        end else begin
            state          <= state_nxt;
            data_valid_out <= 1'b0;
            par_err_out    <= 1'b0;
            stp_err_out    <= 1'b0;

            // Frame settings are frozen here so mid-frame input changes cannot
            // corrupt bit timing or the parity decision.
            if (frame_start) begin
                prescale_q  <= prescale_in;
                par_en_q    <= par_en_in;
                par_typ_q   <= par_typ_in;
                frame_bad_q <= 1'b0;
            end

            if ((state == ST_DATA) && bit_done) begin
                shift_q <= {sampled_bit_in, shift_q[DATA_WIDTH-1:1]};
            end

            if ((state == ST_PARITY) && bit_done && par_mismatch) begin
                par_err_out <= 1'b1;
                frame_bad_q <= 1'b1;
            end

            if ((state == ST_STOP) && bit_done) begin
                if (!sampled_bit_in) begin
                    stp_err_out <= 1'b1;
                end else if (!frame_bad_q) begin
                    p_data_out     <= shift_q;
                    data_valid_out <= 1'b1;
                end
            end
        end
    end

endmodule
